// File: rtl/converte_binario_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds FSM state encodings and BCD limits.
package converte_binario_bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam int BCD_WIDTH = 8;
  localparam int LIMITE_BCD = 99;
  localparam logic [BCD_WIDTH-1:0] BCD_SATURADO = 8'h99;

endpackage

// File: rtl/converte_binario_bcd_if.sv
// Start/done bus between controller and converter.
// master: drives binario/converte; slave: returns bcd/overflow/pronto/ocupado.
interface converte_binario_bcd_if #(
  parameter int LARGURA_BIN = 7
) ();

  logic [LARGURA_BIN-1:0] binario;
  logic                   converte;
  logic [7:0]             bcd;
  logic                   overflow;
  logic                   pronto;
  logic                   ocupado;

  modport master (
    output binario,
    output converte,
    input  bcd,
    input  overflow,
    input  pronto,
    input  ocupado
  );

  modport slave (
    input  binario,
    input  converte,
    output bcd,
    output overflow,
    output pronto,
    output ocupado
  );

endinterface

// File: rtl/converte_binario_bcd_ajusta_digito_bcd.sv
// Combinational add-3 cell for one BCD digit (double dabble).
// Ports: digito (4b in), ajustado (4b out) = digito>=5 ? digito+3 : digito.
module ajusta_digito_bcd (
  input  logic [3:0] digito,
  output logic [3:0] ajustado
);

  always_comb begin
    ajustado = digito;
    if (digito >= 4'd5) ajustado = digito + 4'd3;
  end

endmodule

// File: rtl/converte_binario_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// Ports: clock, reset (sync, active-low), bus (slave side of converte_binario_bcd_if).
module converte_binario_bcd
  import converte_binario_bcd_pkg::*;
#(
  parameter int LARGURA_BIN = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  converte_binario_bcd_if.slave bus
);

  localparam int CW = 3;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA_BIN - 1);
  localparam int TW = BCD_WIDTH + LARGURA_BIN;

  estado_t estado, prox;

  logic [LARGURA_BIN-1:0] desloc;
  logic [BCD_WIDTH-1:0]   acum;
  logic [BCD_WIDTH-1:0]   acum_aj;
  logic [CW-1:0]          cont;
  logic                   flag_ovf;
  logic [TW-1:0]          deslocado;
  logic                   aceita;

  logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
  logic ovf_q, ovf_d;
  logic pronto_q, pronto_d;
  logic ocup_q, ocup_d;

  ajusta_digito_bcd u_dezena (
    .digito   (acum[7:4]),
    .ajustado (acum_aj[7:4])
  );

  ajusta_digito_bcd u_unidade (
    .digito   (acum[3:0]),
    .ajustado (acum_aj[3:0])
  );

  // Correction happens before the shift, so the
  // final shift leaves an uncorrected result.
  assign deslocado = {acum_aj, desloc} << 1;
  assign aceita = (estado == OCIOSO) && bus.converte;

  always_ff @(posedge clock) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  prox = bus.converte ? DESLOCA : OCIOSO;
      DESLOCA: prox = (cont == ULTIMO) ? FIM : DESLOCA;
      FIM:     prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    pronto_d = 1'b0;
    // Busy stays up through the pronto cycle.
    ocup_d   = (prox != OCIOSO) || (estado == FIM);
    if (estado == FIM) begin
      bcd_d    = flag_ovf ? BCD_SATURADO : acum;
      ovf_d    = flag_ovf;
      pronto_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      pronto_q <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      pronto_q <= pronto_d;
      ocup_q   <= ocup_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      desloc   <= '0;
      acum     <= '0;
      cont     <= '0;
      flag_ovf <= 1'b0;
    end else if (aceita) begin
      desloc   <= bus.binario;
      acum     <= '0;
      cont     <= '0;
      flag_ovf <= 32'(bus.binario) > LIMITE_BCD;
    end else if (estado == DESLOCA) begin
      acum   <= deslocado[TW-1 -: BCD_WIDTH];
      desloc <= deslocado[LARGURA_BIN-1:0];
      cont   <= cont + CW'(1);
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.pronto   = pronto_q;
  assign bus.ocupado  = ocup_q;

endmodule

// File: doc/converte_binario_bcd.md
Name: converte_binario_bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method. It feeds the two-digit BCD ASCII serial transmitter directly upstream. It takes a binary measurement and produces the two-digit packed BCD byte that the transmitter consumes. A start/done handshake lets the system controller chain "convert, then transmit".

Parameters:
LARGURA_BIN, 7, width of the binary input. Legal range is 4..7.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
binario  input  LARGURA_BIN  unsigned value to convert; sampled only on an accepted start
converte  input  1  start request; level- or pulse-driven; accepted only in OCIOSO
bcd  output  8  packed BCD: [7:4] tens, [3:0] units; held until the next conversion finishes
overflow  output  1  high when the last converted value exceeded 99; held with bcd
pronto  output  1  one-cycle pulse when bcd/overflow are updated
ocupado  output  1  high from the cycle after acceptance until pronto, inclusive

Behaviour:
- Reset (reset=0 at an edge):
  - state OCIOSO
  - bcd=8'h00, overflow=0, pronto=0, ocupado=0
  - shift counter and internal registers cleared
  - Reset has priority over everything, including mid-conversion; an aborted conversion never produces pronto.
- States: OCIOSO, DESLOCA, FIM. All outputs are registered.
- OCIOSO:
  - If converte=1 at an edge: load shift register with binario, clear 8-bit BCD accumulator, counter=0, latch (binario>99) into flag_ovf, go to DESLOCA.
  - Otherwise stay.
- DESLOCA, once per cycle:
  - Each nibble of the accumulator that is >=5 gets +3 (combinational).
  - Then shift {accumulator, shift register} left by one; counter++.
  - After LARGURA_BIN iterations (counter==LARGURA_BIN-1 at the edge) go to FIM.
- FIM, one cycle:
  - bcd := flag_ovf ? 8'h99 : accumulator
  - overflow := flag_ovf
  - pronto=1
  - Next state OCIOSO.
- Latency: converte sampled at edge T, then pronto high during cycle T+LARGURA_BIN+1. For LARGURA_BIN=7 that is 8 cycles. The updated bcd is visible in the same cycle as pronto.
- Throughput: a new converte can be accepted in the cycle after FIM. Minimum period is LARGURA_BIN+2 cycles.
- converte=1 while in DESLOCA or FIM is ignored, not queued; binario changes during a conversion have no effect.
- Saturation: 7-bit inputs 100..127 give bcd=8'h99, overflow=1. For LARGURA_BIN<=6 overflow is always 0.
- bcd/overflow change only in FIM or on reset. Downstream may sample them at any time after pronto.
- Accumulator is exactly 8 bits. The +3 correction is applied before the shift, never after the final shift.

Decomposition:
- Shared package holds:
  - state encodings OCIOSO/DESLOCA/FIM
  - BCD_SATURADO = 8'h99
  - LIMITE_BCD = 99
  - BCD_WIDTH = 8
- One natural sub-module: ajusta_digito_bcd, a combinational 4-bit cell (out = in>=5 ? in+3 : in), instantiated twice.
- FSM and datapath stay in the top module; no further split.

Test Plan:
- Hold reset=0 for 2 cycles with converte=1 -> bcd=00, overflow=0, pronto=0, ocupado=0 throughout; no conversion starts.
- binario=42, converte pulse at T -> ocupado high T+1..T+8, pronto single pulse at T+8, bcd=8'h42, overflow=0.
- Sweep binario=0..99 back-to-back, each converte issued the cycle after the previous pronto -> bcd equals decimal digits of binario every time (0->00, 9->09, 10->10, 99->99).
- binario=100 and binario=127 -> bcd=8'h99, overflow=1. A following binario=5 -> bcd=8'h05, overflow=0.
- binario=37 accepted, then at T+3 binario=88 with converte=1 -> ignored; result is 8'h37 at T+8; no second pronto.
- binario=64 accepted, reset=0 at T+4 for one cycle -> no pronto, bcd=00, state OCIOSO. A new converte with 64 then yields 8'h64 after 8 cycles.
